// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
// Feeds a four-digit multiplexed seven-segment display. A 16-bit value is
// accepted over a valid/ready handshake and shown either as four hex digits
// or, after a 16-cycle sequential double-dabble conversion, as four decimal
// digits. A free-running prescaler steps the selected digit.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   value_valid  value/mode presented this cycle
//   value_ready  block can accept a value (low while converting)
//   value        16-bit value to display
//   mode         0 = hex, 1 = decimal (sampled at acceptance)
//   blank_lz     blank leading zero digits (live level)
//   digit_code   nibble of the selected digit, to the segment decoder
//   digit_en     active-low one-hot digit select, bit 0 = least significant
//   ovf          last accepted decimal value exceeded 9999
//   busy         decimal conversion in progress
module ssd_scan_driver #(
  parameter int PRESCALE = 50000,
  parameter int DIGITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic [15:0] value,
  input  logic        mode,
  input  logic        blank_lz,
  output logic [3:0]  digit_code,
  output logic [3:0]  digit_en,
  output logic        ovf,
  output logic        busy
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t         state_r, state_s;
  logic [15:0]    disp_r, disp_s;
  logic           ovf_r, ovf_s;
  logic [15:0]    bin_r, bin_s;
  logic [15:0]    bcd_r, bcd_s;
  logic [3:0]     iter_r, iter_s;
  logic [15:0]    adj_s;
  logic [PW-1:0]  presc_r;
  logic [1:0]     idx_r;
  logic           blank_s;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Display, overflow and converter datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r <= 16'h0000;
      ovf_r  <= 1'b0;
      bin_r  <= 16'h0000;
      bcd_r  <= 16'h0000;
      iter_r <= 4'd0;
    end else begin
      disp_r <= disp_s;
      ovf_r  <= ovf_s;
      bin_r  <= bin_s;
      bcd_r  <= bcd_s;
      iter_r <= iter_s;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_s     = state_r;
    disp_s      = disp_r;
    ovf_s       = ovf_r;
    bin_s       = bin_r;
    bcd_s       = bcd_r;
    iter_s      = iter_r;
    adj_s       = add3(bcd_r);
    value_ready = (state_r == IDLE);
    busy        = (state_r == CONV);
    case (state_r)
      IDLE: begin
        if (value_valid) begin
          if (!mode) begin
            disp_s = value;
            ovf_s  = 1'b0;
          end else if (value > 16'd9999) begin
            disp_s = 16'h9999;
            ovf_s  = 1'b1;
          end else begin
            bin_s   = value;
            bcd_s   = 16'h0000;
            iter_s  = 4'd0;
            state_s = CONV;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CONV: begin
        // One iteration: corrected BCD and binary shift left as one word.
        {bcd_s, bin_s} = {adj_s[14:0], bin_r, 1'b0};
        if (iter_r == 4'd15) begin
          // Last iteration lands straight in the display register.
          disp_s  = {adj_s[14:0], bin_r[15]};
          ovf_s   = 1'b0;
          state_s = IDLE;
        end else begin
          iter_s = iter_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Free-running digit prescaler and index, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
      idx_r   <= 2'd0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
      idx_r   <= idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Digit mux and leading-zero blanking; digit 0 is never blanked.
  always_comb begin
    digit_code = 4'h0;
    blank_s    = 1'b0;
    case (idx_r)
      2'd0: begin
        digit_code = disp_r[3:0];
        blank_s    = 1'b0;
      end
      2'd1: begin
        digit_code = disp_r[7:4];
        blank_s    = blank_lz && (disp_r[15:4] == 12'h000);
      end
      2'd2: begin
        digit_code = disp_r[11:8];
        blank_s    = blank_lz && (disp_r[15:8] == 8'h00);
      end
      2'd3: begin
        digit_code = disp_r[15:12];
        blank_s    = blank_lz && (disp_r[15:12] == 4'h0);
      end
      default: begin
        digit_code = 4'h0;
        blank_s    = 1'b0;
      end
    endcase
    if (blank_s) begin
      digit_en = 4'b1111;
    end else begin
      digit_en = ~(4'b0001 << idx_r);
    end
  end

  assign ovf = ovf_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [15:0] value = 16'h0000;
  logic        mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit_code;
  logic [3:0]  digit_en;
  logic        ovf;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  ssd_scan_driver #(.PRESCALE(P), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .value_valid(value_valid), .value_ready(value_ready),
    .value(value), .mode(mode), .blank_lz(blank_lz), .digit_code(digit_code),
    .digit_en(digit_en), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: time since reset, displayed number, pending conversion.
  int          m_n = 0;
  int          m_left = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  logic        m_ovf = 1'b0;
  logic        started = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    int r;
    r = ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    return r[15:0];
  endfunction

  function automatic int m_idx();
    return (m_n / P) % 4;
  endfunction

  function automatic logic [3:0] m_code();
    int d;
    d = (int'(m_disp) >> (4 * m_idx())) & 15;
    return d[3:0];
  endfunction

  function automatic logic [3:0] m_en();
    int hi;
    logic [3:0] one;
    hi = int'(m_disp) >> (4 * m_idx());
    if (blank_lz && m_idx() > 0 && hi == 0) return 4'b1111;
    one = 4'b0001 << m_idx();
    return ~one;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      m_n = 0; m_left = 0; m_disp = 16'h0000; m_ovf = 1'b0;
    end else begin
      m_n++;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_disp = m_pend;
          m_ovf  = 1'b0;
        end
      end else if (value_valid) begin
        if (!mode) begin
          m_disp = value; m_ovf = 1'b0;
        end else if (int'(value) > 9999) begin
          m_disp = 16'h9999; m_ovf = 1'b1;
        end else begin
          m_pend = to_bcd(int'(value)); m_left = 16;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("digit_code", {12'h000, digit_code}, {12'h000, m_code()});
      chk("digit_en",   {12'h000, digit_en},   {12'h000, m_en()});
      chk("value_ready", {15'h0, value_ready}, {15'h0, (m_left == 0)});
      chk("busy", {15'h0, busy}, {15'h0, (m_left > 0)});
      chk("ovf",  {15'h0, ovf},  {15'h0, m_ovf});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] v, input logic md);
    value_valid = 1'b1; value = v; mode = md;
    step(1);
    value_valid = 1'b0;
  endtask

  // Walk 16 cycles, checking digit code/enable against literal per-index tables.
  task automatic walk_codes(input string name, input logic [15:0] codes);
    for (int i = 0; i < 16; i++) begin
      chk(name, {12'h000, digit_code}, {12'h000, codes[4*m_idx() +: 4]});
      step(1);
    end
  endtask

  task automatic walk_en(input string name, input logic [15:0] ens);
    for (int i = 0; i < 16; i++) begin
      chk(name, {12'h000, digit_en}, {12'h000, ens[4*m_idx() +: 4]});
      step(1);
    end
  endtask

  int bcnt;

  initial begin
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_en", {12'h0, digit_en}, 16'h000E);
    chk("rst_code", {12'h0, digit_code}, 16'h0000);
    chk("rst_ready", {15'h0, value_ready}, 16'h0001);
    chk("rst_busy_ovf", {14'h0, busy, ovf}, 16'h0000);
    step(4);
    chk("scan1", {12'h0, digit_en}, 16'h000D);
    step(4);
    chk("scan2", {12'h0, digit_en}, 16'h000B);
    step(4);
    chk("scan3", {12'h0, digit_en}, 16'h0007);
    step(4);
    chk("scan_wrap", {12'h0, digit_en}, 16'h000E);

    // Hex BEEF: digit 0..3 = F, E, E, B.
    step(1);
    send(16'hBEEF, 1'b0);
    walk_codes("hex_beef", 16'hBEEF);

    // Decimal 1234 with an ignored 5678 pulse during conversion.
    send(16'd1234, 1'b1);
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcnt++;
      if (i == 3) begin
        value_valid = 1'b1; value = 16'd5678; mode = 1'b1;
      end else begin
        value_valid = 1'b0;
      end
      step(1);
    end
    chk("busy_cycles", bcnt[15:0], 16'd16);
    chk("model_1234", m_disp, 16'h1234);
    walk_codes("dec_1234", 16'h1234);

    // Decimal overflow, then hex clears ovf.
    send(16'd12345, 1'b1);
    chk("ovf_set", {15'h0, ovf}, 16'h0001);
    chk("ovf_busy", {15'h0, busy}, 16'h0000);
    chk("model_9999", m_disp, 16'h9999);
    walk_codes("ovf_9999", 16'h9999);
    send(16'h0042, 1'b0);
    chk("ovf_clear", {15'h0, ovf}, 16'h0000);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    send(16'h0070, 1'b0);
    walk_en("blank_0070", 16'hFFDE);
    send(16'h0000, 1'b0);
    walk_en("blank_0000", 16'hFFFE);
    walk_codes("zero_code", 16'h0000);
    blank_lz = 1'b0;

    // Reset in the 8th conversion cycle aborts cleanly.
    send(16'd9999, 1'b1);
    step(7);
    chk("conv_busy", {15'h0, busy}, 16'h0001);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_busy", {15'h0, busy}, 16'h0000);
    chk("abort_ready", {15'h0, value_ready}, 16'h0001);
    chk("abort_en", {12'h0, digit_en}, 16'h000E);
    chk("abort_code", {12'h0, digit_code}, 16'h0000);
    step(20);
    chk("abort_disp", m_disp, 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      blank_lz    = $urandom_range(0, 1) == 1;
      value_valid = $urandom_range(0, 3) == 0;
      mode        = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0: value = 16'($urandom_range(0, 99));
        1: value = 16'($urandom_range(0, 10010));
        default: value = 16'($urandom);
      endcase
      step(1);
    end
    rst = 1'b0; value_valid = 1'b0;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
